alu_exec_pipe: RTL

Two-stage pipelined execute unit that consumes the 3-bit ALUControl code produced by the ALU decoder, together with two operands, and returns a registered result plus Zero/Negative/Carry/OverFlow flags. It sits between decode and memory/writeback and uses valid/ready handshakes on both sides, so it can be stalled by a slow downstream stage without losing operations. Throughput is one operation per cycle, and latency is two cycles.

---
 rtl/alu_exec_pipe.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/alu_exec_pipe.sv
// alu_exec_pipe: two-stage elastic execute unit.
//   S1 registers the operation code and both operands.
//   S2 computes the ALU function from the S1 registers and registers Result and the flags.
// Both sides use valid/ready handshakes, so a stalled consumer never loses an operation.
//
// Ports
//   clk, rst           rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready  upstream handshake; ALUControl, SrcA and SrcB are qualified by in_valid
//   out_valid/out_ready downstream handshake; Result and the flags are qualified by out_valid
//   Result             registered result
//   Zero, Negative     derived from Result
//   Carry, OverFlow    adder carry-out / signed overflow for ADD and SUB, 0 otherwise
module alu_exec_pipe #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             OverFlow
);

  typedef enum logic [2:0] {
    OpAdd   = 3'b000,
    OpSub   = 3'b001,
    OpAnd   = 3'b010,
    OpOr    = 3'b011,
    OpXor   = 3'b100,
    OpSlt   = 3'b101,
    OpSltu  = 3'b110,
    OpPassB = 3'b111
  } alu_op_e;

  localparam int unsigned Msb = WIDTH - 1;

  // Stage 1 registers
  logic             s1_valid_q;
  alu_op_e          s1_op_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;

  // Stage 2 registers
  logic             s2_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q, negative_q, carry_q, overflow_q;

  logic s1_advance, s2_advance;

  // A stage may load when it is empty or when its content leaves this cycle.
  assign s2_advance = !s2_valid_q || out_ready;
  assign s1_advance = !s1_valid_q || s2_advance;
  assign in_ready   = s1_advance;

  // Datapath
  logic [WIDTH:0]   add_sum, sub_sum;
  logic             add_ovf, sub_ovf, slt, sltu;
  logic [WIDTH-1:0] result_d;
  logic             zero_d, negative_d, carry_d, overflow_d;

  always_comb begin
    add_sum = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    sub_sum = {1'b0, s1_a_q} + {1'b0, ~s1_b_q} + {{WIDTH{1'b0}}, 1'b1};
    add_ovf = (s1_a_q[Msb] == s1_b_q[Msb]) && (add_sum[Msb] != s1_a_q[Msb]);
    sub_ovf = (s1_a_q[Msb] != s1_b_q[Msb]) && (sub_sum[Msb] != s1_a_q[Msb]);
    // True signed less-than: the raw sign of A-B is wrong whenever the subtraction overflows.
    slt     = sub_sum[Msb] ^ sub_ovf;
    // Carry-out of A+~B+1 is the "no borrow" flag, so unsigned less-than is its inverse.
    sltu    = ~sub_sum[WIDTH];

    result_d   = '0;
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    unique case (s1_op_q)
      OpAdd: begin
        result_d   = add_sum[WIDTH-1:0];
        carry_d    = add_sum[WIDTH];
        overflow_d = add_ovf;
      end
      OpSub: begin
        result_d   = sub_sum[WIDTH-1:0];
        carry_d    = sub_sum[WIDTH];
        overflow_d = sub_ovf;
      end
      OpAnd:   result_d = s1_a_q & s1_b_q;
      OpOr:    result_d = s1_a_q | s1_b_q;
      OpXor:   result_d = s1_a_q ^ s1_b_q;
      OpSlt:   result_d = {{(WIDTH-1){1'b0}}, slt};
      OpSltu:  result_d = {{(WIDTH-1){1'b0}}, sltu};
      OpPassB: result_d = s1_b_q;
      default: result_d = '0;
    endcase
    zero_d     = (result_d == '0);
    negative_d = result_d[Msb];
  end

  // Stage 1: data loads on every advance, even when in_valid is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= OpAdd;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else if (s1_advance) begin
      s1_valid_q <= in_valid;
      s1_op_q    <= alu_op_e'(ALUControl);
      s1_a_q     <= SrcA;
      s1_b_q     <= SrcB;
    end
  end

  // Stage 2: s2_valid takes s1_valid on advance, which collapses bubbles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b1;
      negative_q <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else if (s2_advance) begin
      s2_valid_q <= s1_valid_q;
      result_q   <= result_d;
      zero_q     <= zero_d;
      negative_q <= negative_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign Result    = result_q;
  assign Zero      = zero_q;
  assign Negative  = negative_q;
  assign Carry     = carry_q;
  assign OverFlow  = overflow_q;

endmodule
